// File: rtl/layer_seq_pkg.sv
// ---------------------------------------------------------------------------
// layer_seq_pkg
// Shared definitions for the layer sequencer:
//   - state_e : controller state encoding
//   - BIAS_EN : set when LAYER_SEQ_BIAS_EN is defined at build time
//   - steps_f : MAC steps per neuron (N_IN, or N_IN+1 with the bias input)
// Build option: LAYER_SEQ_BIAS_EN appends a constant-1 bias step per neuron.
// ---------------------------------------------------------------------------
package layer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_ACT   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

`ifdef LAYER_SEQ_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  // The bias step uses in_idx = N_IN, which the datapath decodes as 1.0.
  function automatic int steps_f(input int n_in);
    return BIAS_EN ? (n_in + 1) : n_in;
  endfunction

endpackage

// File: rtl/layer_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// layer_seq_addr_gen
// Input/neuron index counters and weight-address generation.
// Ports:
//   clk, rst      : falling-edge clock, async active-high reset
//   clr_i         : return both counters to 0
//   step_i        : one MAC step completed (advance / wrap in_idx)
//   next_i        : advance to the next neuron (out_idx + 1)
//   in_idx_o      : current input index
//   out_idx_o     : current neuron index
//   w_addr_o      : out_idx*STEPS + in_idx, full AW width
//   last_in_o     : in_idx is the final step of the neuron
//   last_out_o    : out_idx is the final neuron of the layer
// Build option: LAYER_SEQ_BIAS_EN (via layer_seq_pkg::steps_f).
// ---------------------------------------------------------------------------
module layer_seq_addr_gen
  import layer_seq_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int IW    = $clog2(N_IN + 1),
  parameter int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int AW    = $clog2(N_OUT * (N_IN + 1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          step_i,
  input  logic          next_i,
  output logic [IW-1:0] in_idx_o,
  output logic [OW-1:0] out_idx_o,
  output logic [AW-1:0] w_addr_o,
  output logic          last_in_o,
  output logic          last_out_o
);

  localparam int STEPS = steps_f(N_IN);

  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [OW-1:0] out_idx_q, out_idx_d;
  logic          last_in, last_out;

  assign last_in  = (in_idx_q == IW'(STEPS - 1));
  assign last_out = (out_idx_q == OW'(N_OUT - 1));

  // Counters stop at their bounds: in_idx wraps to 0 only through the
  // end-of-neuron path, out_idx saturates at N_OUT-1.
  always_comb begin
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    if (clr_i) begin
      in_idx_d  = '0;
      out_idx_d = '0;
    end else begin
      if (step_i) begin
        in_idx_d = last_in ? '0 : (in_idx_q + IW'(1));
      end
      if (next_i && !last_out) begin
        out_idx_d = out_idx_q + OW'(1);
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      in_idx_q  <= '0;
      out_idx_q <= '0;
    end else begin
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign in_idx_o   = in_idx_q;
  assign out_idx_o  = out_idx_q;
  assign w_addr_o   = (AW'(out_idx_q) * AW'(STEPS)) + AW'(in_idx_q);
  assign last_in_o  = last_in;
  assign last_out_o = last_out;

endmodule

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Schedules one fully-connected layer through a shared MAC unit and a shared
// activation unit: per neuron CLEAR -> MAC x STEPS -> ACT -> WRITE, then DONE.
// State updates on the falling clock edge; reset is async active-high.
//
//   state | meaning
//   IDLE  | waiting for start, all strobes low
//   CLEAR | one-cycle accumulator clear
//   MAC   | mac_req held, one step per mac_ack
//   ACT   | act_req held until act_ack
//   WRITE | one-cycle output write at out_idx
//   DONE  | one-cycle done pulse, counters return to 0
//
// Ports:
//   clk, rst            : clock (falling edge), async active-high reset
//   start               : layer start, sampled in IDLE only
//   busy, done          : layer in progress / layer finished pulse
//   mac_clr, mac_req    : accumulator clear / MAC step request
//   mac_ack             : MAC step complete
//   in_idx, w_addr      : operand index and weight address for the MAC step
//   act_req, act_ack    : activation handshake
//   out_we, out_idx     : output register write enable and neuron index
// Build option: LAYER_SEQ_BIAS_EN adds a bias step (in_idx = N_IN) per neuron.
// ---------------------------------------------------------------------------
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int IW    = $clog2(N_IN + 1),
  parameter int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int AW    = $clog2(N_OUT * (N_IN + 1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mac_clr,
  output logic          mac_req,
  input  logic          mac_ack,
  output logic [IW-1:0] in_idx,
  output logic [AW-1:0] w_addr,
  output logic          act_req,
  input  logic          act_ack,
  output logic          out_we,
  output logic [OW-1:0] out_idx
);

  state_e state_q, state_d;
  logic   last_in, last_out;
  logic   cnt_clr, cnt_step, cnt_next;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_MAC;
      ST_MAC:   if (mac_ack && last_in) state_d = ST_ACT;
      ST_ACT:   if (act_ack) state_d = ST_WRITE;
      ST_WRITE: state_d = last_out ? ST_DONE : ST_CLEAR;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    mac_clr  = (state_q == ST_CLEAR);
    mac_req  = (state_q == ST_MAC);
    act_req  = (state_q == ST_ACT);
    out_we   = (state_q == ST_WRITE);
    // Counters are held at 0 in IDLE, so a start always begins at neuron 0.
    cnt_clr  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    cnt_step = (state_q == ST_MAC) && mac_ack;
    cnt_next = (state_q == ST_WRITE) && !last_out;
  end

  layer_seq_addr_gen #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .IW    (IW),
    .OW    (OW),
    .AW    (AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .step_i     (cnt_step),
    .next_i     (cnt_next),
    .in_idx_o   (in_idx),
    .out_idx_o  (out_idx),
    .w_addr_o   (w_addr),
    .last_in_o  (last_in),
    .last_out_o (last_out)
  );

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

  localparam int N_IN = 2;
`ifdef LAYER_SEQ_BIAS_EN
  localparam int N_OUT = 3;
  localparam int STEPS = N_IN + 1;
  localparam int LAT_FAST = 18;
  localparam int LAT_SLOW = 45;
  localparam int EXP_MACS = 9;
`else
  localparam int N_OUT = 2;
  localparam int STEPS = N_IN;
  localparam int LAT_FAST = 10;
  localparam int LAT_SLOW = 22;
  localparam int EXP_MACS = 4;
`endif
  localparam int IW  = $clog2(N_IN + 1);
  localparam int OW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int AW  = $clog2(N_OUT * (N_IN + 1));
  localparam int PER = STEPS + 3;          // CLEAR, STEPS MACs, ACT, WRITE
  localparam int LAST = N_OUT * PER;       // position of the DONE cycle

  logic          clk, rst, start, mac_ack, act_ack;
  logic          busy, done, mac_clr, mac_req, act_req, out_we;
  logic [IW-1:0] in_idx;
  logic [AW-1:0] w_addr;
  logic [OW-1:0] out_idx;

  layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mac_clr(mac_clr), .mac_req(mac_req), .mac_ack(mac_ack),
    .in_idx(in_idx), .w_addr(w_addr), .act_req(act_req), .act_ack(act_ack),
    .out_we(out_we), .out_idx(out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the layer is a linear list of one-cycle slots
  // (CLEAR, MAC 0..STEPS-1, ACT, WRITE per neuron, then DONE); MAC and ACT
  // slots advance only on their ack.
  bit  m_busy = 1'b0;
  int  m_pos  = 0;
  int  cyc    = 0;
  int  acc_cyc = 0;
  int  done_cyc = 0;
  int  addr_log[$];
  int  we_log[$];
  bit  s_req, s_we;
  int  s_waddr, s_oidx;

  always @(negedge clk) begin
    int r;
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_pos  = 0;
    end else begin
      if (s_req && mac_ack) addr_log.push_back(s_waddr);
      if (s_we) we_log.push_back(s_oidx);
      if (!m_busy) begin
        if (start) begin
          m_busy  = 1'b1;
          m_pos   = 0;
          acc_cyc = cyc;
        end
      end else if (m_pos == LAST) begin
        m_busy = 1'b0;
        m_pos  = 0;
      end else begin
        r = m_pos % PER;
        if (r >= 1 && r <= STEPS) begin
          if (mac_ack) m_pos++;
        end else if (r == STEPS + 1) begin
          if (act_ack) m_pos++;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(posedge clk) begin
    int n, r;
    logic [5:0] e;
    s_req   = mac_req;
    s_we    = out_we;
    s_waddr = int'(w_addr);
    s_oidx  = int'(out_idx);
    if (done) done_cyc = cyc;
    n = m_pos / PER;
    r = m_pos % PER;
    if (!m_busy) begin
      e = 6'b000000;
    end else if (m_pos == LAST) begin
      e = 6'b110000;
    end else begin
      e = {1'b1, 1'b0, (r == 0), (r >= 1 && r <= STEPS), (r == STEPS + 1), (r == STEPS + 2)};
    end
    check("strobes{busy,done,clr,req,act,we}",
          int'({busy, done, mac_clr, mac_req, act_req, out_we}), int'(e));
    if (!m_busy) begin
      check("idle_in_idx", int'(in_idx), 0);
      check("idle_out_idx", int'(out_idx), 0);
      check("idle_w_addr", int'(w_addr), 0);
    end else if (m_pos != LAST) begin
      check("out_idx", int'(out_idx), n);
      if (r >= 1 && r <= STEPS) begin
        check("in_idx", int'(in_idx), r - 1);
        check("w_addr", int'(w_addr), n * STEPS + (r - 1));
      end
    end
  end

  task automatic drive_acks(input int mode, inout int w);
    case (mode)
      1: begin
        act_ack = 1'b1;
        if (mac_req) begin
          if (w == 3) begin mac_ack = 1'b1; w = 0; end
          else begin mac_ack = 1'b0; w++; end
        end else begin
          mac_ack = 1'b0;
        end
      end
      2: begin
        mac_ack = 1'($urandom_range(0, 1));
        act_ack = 1'($urandom_range(0, 1));
      end
      default: begin
        mac_ack = 1'b1;
        act_ack = 1'b1;
      end
    endcase
  endtask

  // mode 0: acks high; 1: mac_ack after 3 wait cycles; 2: random acks;
  // 3: acks high plus random start pulses while busy.
  task automatic run_layer(input int mode, output int lat);
    int w = 0;
    int cnt;
    addr_log.delete();
    we_log.delete();
    @(posedge clk); #1;
    start = 1'b1;
    drive_acks(mode, w);
    for (cnt = 0; cnt < 400; cnt++) begin
      @(posedge clk); #1;
      if (done) break;
      start = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_acks(mode, w);
    end
    start = 1'b0;
    if (cnt == 400) check("done_timeout", int'(done), 1);
    lat = done_cyc - acc_cyc;
  endtask

  task automatic verify_seq(input string tag);
    check({tag, "_mac_count"}, addr_log.size(), EXP_MACS);
    foreach (addr_log[i]) check({tag, "_addr_seq"}, addr_log[i], i);
    check({tag, "_we_count"}, we_log.size(), N_OUT);
    foreach (we_log[i]) check({tag, "_we_idx"}, we_log[i], i);
  endtask

  initial begin
    int lat;
    int cnt;
    rst = 1'b0; start = 1'b0; mac_ack = 1'b0; act_ack = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_mac_req", int'(mac_req), 0);
    check("reset_w_addr", int'(w_addr), 0);
    rst = 1'b0;

    run_layer(0, lat);
    check("fast_latency", lat, LAT_FAST);
    verify_seq("fast");

    run_layer(1, lat);
    check("slow_latency", lat, LAT_SLOW);
    verify_seq("slow");

    run_layer(3, lat);
    check("spurious_latency", lat, LAT_FAST);
    verify_seq("spurious");

    // Async reset during the second MAC step of the first neuron.
    @(posedge clk); #1;
    start = 1'b1; mac_ack = 1'b1; act_ack = 1'b1;
    for (cnt = 0; cnt < 50; cnt++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mac_req && w_addr == 1) break;
    end
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_w_addr", int'(w_addr), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_mac_req", int'(mac_req), 0);
    check("rst_in_idx", int'(in_idx), 0);
    check("rst_w_addr", int'(w_addr), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_layer(0, lat);
    check("restart_latency", lat, LAT_FAST);
    verify_seq("restart");

    // rst and start together, then rst released with start low.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("rst_start_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("after_rst_start_busy", int'(busy), 0);
    end

    repeat (6) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_layer(2, lat);
      verify_seq("random");
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Controller that sequences one fully-connected layer of the network through a single shared multiply-accumulate (MAC) unit and a single activation unit. For each output neuron it clears the accumulator, issues one MAC request per input with the matching weight address, runs the activation, and writes the result to the output register. It sits between the network-level controller (start/done) and the layer datapath (MAC, activation, output register), replacing per-layer ack counters with one explicit scheduler.

## Interface
Parameters:
- N_IN, 2, inputs per neuron (≥1)
- N_OUT, 2, neurons in the layer (≥1)
- IW, $clog2(N_IN+1), width of in_idx
- OW, $clog2(N_OUT), width of out_idx (minimum 1)
- AW, $clog2(N_OUT*(N_IN+1)), width of w_addr

Ports:
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  layer start request, sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse when the whole layer has been written
- mac_clr  out  1  one-cycle accumulator clear
- mac_req  out  1  MAC step request, held until mac_ack
- mac_ack  in  1  MAC step complete
- in_idx  out  IW  input-vector index for the current MAC step
- w_addr  out  AW  weight-memory address for the current MAC step
- act_req  out  1  activation request, held until act_ack
- act_ack  in  1  activation result valid
- out_we  out  1  one-cycle output-register write enable
- out_idx  out  OW  neuron index being processed or written

## Operation
- States: IDLE, CLEAR, MAC, ACT, WRITE, DONE.
- IDLE: all strobes low. start=1 → CLEAR, with neuron counter = 0 and in_idx = 0. start is ignored in every other state.
- CLEAR: mac_clr=1 for exactly one cycle → MAC.
- MAC: mac_req=1; in_idx and w_addr are stable while mac_req is high.
  - w_addr = out_idx*STEPS + in_idx, where STEPS = N_IN (N_IN+1 when bias is enabled).
  - mac_ack=1: if in_idx = STEPS-1, go to ACT with in_idx = 0. Otherwise increment in_idx and stay in MAC, with mac_req held high for the next step.
- ACT: act_req=1 until act_ack=1 → WRITE.
- WRITE: out_we=1 for one cycle at the current out_idx. Then:
  - if out_idx = N_OUT-1 → DONE;
  - otherwise increment out_idx → CLEAR.
- DONE: done=1 for one cycle → IDLE. out_idx returns to 0.
- mac_ack outside MAC and act_ack outside ACT are ignored; no counter moves.
- Arithmetic: counters are unsigned, compare against the parameter bounds, and never wrap past them. w_addr is computed at AW width without truncation.
- Reset, asynchronous at any time including mid-layer: state = IDLE, all counters = 0, and every output = 0 (busy, done, mac_clr, mac_req, act_req, out_we, in_idx, w_addr, out_idx). The in-progress layer is abandoned and is not resumed.
- rst and start asserted together: rst wins.

## Timing
- start is accepted on edge k. CLEAR occupies edge k+1, and the first mac_req is visible after edge k+1.
- Each MAC step costs 1 cycle when mac_ack is already high in the first request cycle, plus one cycle per wait cycle. ACT follows the same rule with act_ack.
- With zero-wait acks, each neuron takes STEPS+3 cycles (CLEAR, STEPS MAC cycles, ACT, WRITE).
- With zero-wait acks, done rises N_OUT*(STEPS+3) cycles after start is accepted.
- busy is high from the CLEAR cycle through the DONE cycle inclusive.
- A new start is accepted the cycle after DONE.

## Configuration
- LAYER_SEQ_BIAS_EN defined: STEPS = N_IN+1. The final MAC step of each neuron uses in_idx = N_IN, which the datapath decodes as a constant-1 input, so the bias weight is stored after that neuron's weights.
- LAYER_SEQ_BIAS_EN not defined: STEPS = N_IN and in_idx never reaches N_IN. AW is unchanged.

## Structure
- A shared package, layer_seq_pkg, holds:
  - the state enum (IDLE, CLEAR, MAC, ACT, WRITE, DONE);
  - the STEPS calculation, as a function of N_IN and the macro.
- One sub-module, layer_seq_addr_gen, holds in_idx, out_idx and w_addr. Its inputs are step/next-neuron/clear strobes; its outputs are the last-input and last-neuron flags. The FSM stays in layer_sequencer.

## Test plan
- N_IN=2, N_OUT=2, no bias, acks tied high, start pulse → w_addr sequence 0,1,2,3; four MAC steps total; out_we at out_idx 0 then 1; done 10 cycles after start.
- Same configuration, mac_ack delayed 3 cycles per step → mac_req held with stable in_idx/w_addr for 4 cycles each; done 22 cycles after start.
- LAYER_SEQ_BIAS_EN, N_IN=2, N_OUT=3 → in_idx runs 0,1,2 per neuron; w_addr runs 0..8; done 18 cycles after start.
- rst asserted asynchronously during the second MAC step → all outputs 0 immediately. A following start restarts at w_addr 0.
- start pulsed while busy, plus spurious mac_ack in ACT and act_ack in MAC → no effect; address sequence and done timing match the first scenario.
- rst and start high together, then rst released → stays in IDLE; busy=0.
